cpu_wb_arbiter: RTL and testbench
=================================

CPU_WB_ARBITER -- requirements
Module: cpu_wb_arbiter

Interface
REQ-001 SHALL have parameter PRIORITY_MODE, default 0, meaning 0 = round-robin between requesters and 1 = fixed priority to requester A.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port hold_i, input, 1, writeback freeze; while high no grants are issued.
REQ-005 SHALL have port a_valid_i, input, 1, requester A (ALU pipe) has a write pending.
REQ-006 SHALL have port a_index_i, input, 4, requester A destination register.
REQ-007 SHALL have port a_result_i, input, 32, requester A write data.
REQ-008 SHALL have port a_ready_o, output, 1, grant to A; the transfer occurs when a_valid_i and a_ready_o are both high.
REQ-009 SHALL have ports b_valid_i (input, 1), b_index_i (input, 4), b_result_i (input, 32) and b_ready_o (output, 1), with the same meanings for requester B (load unit).
REQ-010 SHALL have port register_write_enable_o, output, 1, register file write strobe.
REQ-011 SHALL have port register_write_index_o, output, 4, register file write address.
REQ-012 SHALL have port result_o, output, 32, register file write data.
REQ-013 SHALL have port conflict_count_o, output, 16, count of cycles in which both requesters were valid.

Function
REQ-014 a_ready_o and b_ready_o SHALL be combinational from the valids, hold_i and the arbitration state, and SHALL never both be high in the same cycle.
REQ-015 With hold_i high, both readies SHALL be 0 and the arbitration state SHALL be unchanged.
REQ-016 With exactly one valid and hold_i low, that requester SHALL be granted in the same cycle.
REQ-017 With both valid, different indices and PRIORITY_MODE=0, grant SHALL go to the requester not granted most recently; this is a one-bit last_grant flag, reset value B, so A wins the first conflict.
REQ-018 With both valid, different indices and PRIORITY_MODE=1, A SHALL be granted.
REQ-019 With both valid and a_index_i == b_index_i, B SHALL be granted regardless of mode, so the younger ALU write lands last.
REQ-020 last_grant SHALL update only on an accepted transfer.
REQ-021 An accepted transfer in cycle N SHALL appear on register_write_enable_o=1, register_write_index_o and result_o in cycle N+1, giving a 1-cycle registered latency.
REQ-022 With no transfer in cycle N, register_write_enable_o SHALL be 0 in cycle N+1; index and result SHALL hold their previous values.
REQ-023 The output register SHALL never back-pressure, since the register file accepts a write every cycle; sustained throughput SHALL be 1 write per cycle.
REQ-024 conflict_count_o SHALL increment by 1 in each cycle where a_valid_i and b_valid_i are both high, including while hold_i is high.
REQ-025 conflict_count_o SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-026 A requester SHALL keep its index and result stable while valid is high and not granted; the arbiter SHALL NOT latch inputs before grant.

Reset
REQ-027 While rst_i is high: register_write_enable_o=0, register_write_index_o=4'h0, result_o=32'h0, conflict_count_o=16'h0, last_grant=B, and readies=0, all asynchronously.
REQ-028 Reset asserted mid-transfer SHALL discard the in-flight write; no write strobe SHALL issue in the cycle after reset deasserts unless a new transfer is accepted in that deassert cycle.

Verification
REQ-029 Single requester: A valid, index 3, data 32'hDEADBEEF, for 1 cycle -> a_ready_o=1 same cycle; next cycle enable=1, index=3, result=DEADBEEF; enable=0 the cycle after.
REQ-030 Round-robin conflict (mode 0): A (idx 1) and B (idx 2) both valid continuously for 4 cycles -> grants A,B,A,B; writes idx 1,2,1,2 on cycles 2-5; conflict_count_o=4.
REQ-031 Same-index collision: A and B both target idx 5 (A=32'h1, B=32'h2) -> B granted first, A next; register 5 written 2 then 1.
REQ-032 Fixed priority (mode 1): A and B valid with distinct indices for 3 cycles, then A drops -> A granted 3 cycles, B granted on the 4th.
REQ-033 Hold and saturation: hold_i high for 3 cycles with both valid -> no readies, enable=0, count +3; preload the count near 16'hFFFE with 3 more conflict cycles -> count stops at FFFF.
REQ-034 Reset mid-operation: assert rst_i asynchronously between edges during streaming -> outputs 0 immediately; after release, A wins the first conflict.

Source files
------------

// File: rtl/cpu_wb_arbiter.sv
// Writeback arbiter: merges the ALU pipe (A) and load unit (B) into one
// register-file write port with a 1-cycle registered write stage.

module cpu_wb_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        a_valid_i,
    input  logic [3:0]  a_index_i,
    input  logic [31:0] a_result_i,
    output logic        a_ready_o,
    input  logic        b_valid_i,
    input  logic [3:0]  b_index_i,
    input  logic [31:0] b_result_i,
    output logic        b_ready_o,
    output logic        register_write_enable_o,
    output logic [3:0]  register_write_index_o,
    output logic [31:0] result_o,
    output logic [15:0] conflict_count_o
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    localparam logic FIXED_PRIORITY = (PRIORITY_MODE == 32'sd1);

    grant_e      last_grant_r;
    logic        both_valid_s;
    logic        same_index_s;
    logic        grant_a_s;
    logic        grant_b_s;
    logic        transfer_s;
    logic [3:0]  sel_index_s;
    logic [31:0] sel_result_s;
    logic        wr_en_r;
    logic [3:0]  wr_index_r;
    logic [31:0] wr_result_r;
    logic [15:0] conflict_count_r;

    assign both_valid_s = a_valid_i & b_valid_i;
    assign same_index_s = (a_index_i == b_index_i);

    // Grant decision; reset gating keeps readies low asynchronously while rst_i is high
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (rst_i || hold_i) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (both_valid_s) begin
            // Same destination: the load (older) writes first so the ALU value lands last
            if (same_index_s) begin
                grant_b_s = 1'b1;
            end else if (FIXED_PRIORITY) begin
                grant_a_s = 1'b1;
            end else if (last_grant_r == GRANT_B) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (a_valid_i) begin
            grant_a_s = 1'b1;
        end else if (b_valid_i) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign a_ready_o  = grant_a_s;
    assign b_ready_o  = grant_b_s;
    assign transfer_s = grant_a_s | grant_b_s;

    // Select the granted requester's write payload
    always_comb begin
        sel_index_s  = a_index_i;
        sel_result_s = a_result_i;
        case ({grant_a_s, grant_b_s})
            2'b10: begin
                sel_index_s  = a_index_i;
                sel_result_s = a_result_i;
            end
            2'b01: begin
                sel_index_s  = b_index_i;
                sel_result_s = b_result_i;
            end
            default: begin
                sel_index_s  = a_index_i;
                sel_result_s = a_result_i;
            end
        endcase
    end

    // Registered write stage; index/result hold when no transfer occurs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_en_r     <= 1'b0;
            wr_index_r  <= 4'h0;
            wr_result_r <= 32'h0;
        end else begin
            wr_en_r <= transfer_s;
            if (transfer_s) begin
                wr_index_r  <= sel_index_s;
                wr_result_r <= sel_result_s;
            end
        end
    end

    // Round-robin history, moved only by an accepted transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_r <= GRANT_B;
        end else if (grant_a_s) begin
            last_grant_r <= GRANT_A;
        end else if (grant_b_s) begin
            last_grant_r <= GRANT_B;
        end
    end

    // Saturating count of cycles with both requesters valid, hold or not
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_count_r <= 16'h0000;
        end else if (both_valid_s && (conflict_count_r != 16'hFFFF)) begin
            conflict_count_r <= conflict_count_r + 16'h0001;
        end
    end

    assign register_write_enable_o = wr_en_r;
    assign register_write_index_o  = wr_index_r;
    assign result_o                = wr_result_r;
    assign conflict_count_o        = conflict_count_r;

    cpu_wb_arbiter_chk u_chk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .hold_i    (hold_i),
        .a_valid_i (a_valid_i),
        .b_valid_i (b_valid_i),
        .a_ready   (a_ready_o),
        .b_ready   (b_ready_o)
    );

endmodule

// Grant-protocol properties of the arbiter, kept apart from the datapath.
module cpu_wb_arbiter_chk (
    input logic clk_i,
    input logic rst_i,
    input logic hold_i,
    input logic a_valid_i,
    input logic b_valid_i,
    input logic a_ready,
    input logic b_ready
);

    a_one_grant: assert property (@(posedge clk_i) disable iff (rst_i) !(a_ready && b_ready));
    a_hold_blocks: assert property (@(posedge clk_i) disable iff (rst_i) hold_i |-> !(a_ready || b_ready));
    a_grant_a_valid: assert property (@(posedge clk_i) disable iff (rst_i) a_ready |-> a_valid_i);
    a_grant_b_valid: assert property (@(posedge clk_i) disable iff (rst_i) b_ready |-> b_valid_i);

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Bench for cpu_wb_arbiter: round-robin and fixed-priority instances on shared
// stimulus, checked every cycle against a rule-level model plus literal vectors.

module tb_cpu_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        av, bv;
    logic [3:0]  ai, bi;
    logic [31:0] ar, br;

    logic [1:0]        a_rdy, b_rdy, we;
    logic [1:0][3:0]   widx;
    logic [1:0][31:0]  wres;
    logic [1:0][15:0]  cnt;

    int checks   = 0;
    int failures = 0;

    // model state, index 0 = round-robin instance, 1 = fixed-priority instance
    bit          m_last_a [2];
    bit          m_we     [2];
    logic [3:0]  m_idx    [2];
    logic [31:0] m_res    [2];
    int          m_cnt    [2];
    int          preload_seq = 0;
    int          seen_seq    = 0;
    logic [15:0] preload_val = 16'h0;

    always #5 clk = ~clk;

    cpu_wb_arbiter #(.PRIORITY_MODE(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .hold_i(hold),
        .a_valid_i(av), .a_index_i(ai), .a_result_i(ar), .a_ready_o(a_rdy[0]),
        .b_valid_i(bv), .b_index_i(bi), .b_result_i(br), .b_ready_o(b_rdy[0]),
        .register_write_enable_o(we[0]), .register_write_index_o(widx[0]),
        .result_o(wres[0]), .conflict_count_o(cnt[0])
    );

    cpu_wb_arbiter #(.PRIORITY_MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .hold_i(hold),
        .a_valid_i(av), .a_index_i(ai), .a_result_i(ar), .a_ready_o(a_rdy[1]),
        .b_valid_i(bv), .b_index_i(bi), .b_result_i(br), .b_ready_o(b_rdy[1]),
        .register_write_enable_o(we[1]), .register_write_index_o(widx[1]),
        .result_o(wres[1]), .conflict_count_o(cnt[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Who wins this cycle: 0 nobody, 1 = A, 2 = B
    function automatic int winner(input int mode, input bit last_a);
        if (rst || hold) return 0;
        if (av && bv) begin
            if (ai == bi) return 2;
            if (mode == 1) return 1;
            return last_a ? 2 : 1;
        end
        if (av) return 1;
        if (bv) return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_last_a[i] = 1'b0;
                m_we[i]     = 1'b0;
                m_idx[i]    = 4'h0;
                m_res[i]    = 32'h0;
                m_cnt[i]    = 0;
            end
        end else begin
            if (preload_seq != seen_seq) begin
                m_cnt[0] = int'(preload_val);
                seen_seq = preload_seq;
            end
            for (int i = 0; i < 2; i++) begin
                int g;
                g = winner(i, m_last_a[i]);
                m_we[i] = (g != 0);
                if (g == 1) begin
                    m_idx[i] = ai; m_res[i] = ar; m_last_a[i] = 1'b1;
                end else if (g == 2) begin
                    m_idx[i] = bi; m_res[i] = br; m_last_a[i] = 1'b0;
                end
                if (av && bv) m_cnt[i] = (m_cnt[i] >= 65535) ? 65535 : m_cnt[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int g;
            g = winner(i, m_last_a[i]);
            chk1("model_a_ready", a_rdy[i], g == 1);
            chk1("model_b_ready", b_rdy[i], g == 2);
            chk1("model_wr_en", we[i], m_we[i]);
            chk("model_wr_idx", {28'd0, widx[i]}, {28'd0, m_idx[i]});
            chk("model_wr_data", wres[i], m_res[i]);
            chk("model_count", {16'd0, cnt[i]}, m_cnt[i]);
        end
    end

    task automatic drive(input logic a_v, input logic [3:0] a_i, input logic [31:0] a_r,
                         input logic b_v, input logic [3:0] b_i, input logic [31:0] b_r,
                         input logic h);
        @(posedge clk);
        #1;
        av = a_v; ai = a_i; ar = a_r;
        bv = b_v; bi = b_i; br = b_r;
        hold = h;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        av = 1'b0; bv = 1'b0; hold = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        av = 1'b0; ai = 4'h0; ar = 32'h0;
        bv = 1'b0; bi = 4'h0; br = 32'h0;

        // reset state, readies held low even with both requesters valid
        repeat (2) @(posedge clk);
        #1;
        av = 1'b1; ai = 4'h1; bv = 1'b1; bi = 4'h2;
        #1;
        chk1("rst_a_ready", a_rdy[0], 1'b0);
        chk1("rst_b_ready", b_rdy[0], 1'b0);
        chk1("rst_wr_en", we[0], 1'b0);
        chk("rst_count", {16'd0, cnt[0]}, 32'd0);
        av = 1'b0; bv = 1'b0;
        #1;
        rst = 1'b0;

        // single requester A
        drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b0);
        chk1("single_a_ready", a_rdy[0], 1'b1);
        idle();
        chk1("single_wr_en", we[0], 1'b1);
        chk("single_wr_idx", {28'd0, widx[0]}, 32'd3);
        chk("single_wr_data", wres[0], 32'hDEADBEEF);
        idle();
        chk1("single_wr_en_off", we[0], 1'b0);
        chk("single_idx_hold", {28'd0, widx[0]}, 32'd3);

        // round-robin conflict, fresh from reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0);
            chk1("rr_a_ready", a_rdy[0], (k % 2) == 0);
            chk1("rr_b_ready", b_rdy[0], (k % 2) == 1);
            if (k > 0) chk("rr_wr_idx", {28'd0, widx[0]}, ((k - 1) % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle();
        chk("rr_last_idx", {28'd0, widx[0]}, 32'd2);
        chk("rr_count", {16'd0, cnt[0]}, 32'd4);

        // same-index collision: B first in both modes
        drive(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2, 1'b0);
        chk1("same_b_ready", b_rdy[0], 1'b1);
        chk1("same_b_ready_fixed", b_rdy[1], 1'b1);
        drive(1'b1, 4'd5, 32'h1, 1'b0, 4'd5, 32'h2, 1'b0);
        chk1("same_a_ready", a_rdy[0], 1'b1);
        chk("same_first_data", wres[0], 32'h2);
        idle();
        chk("same_second_data", wres[0], 32'h1);
        chk("same_second_idx", {28'd0, widx[0]}, 32'd5);

        // fixed priority instance: A three times, then B once A drops
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd4, 32'h44, 1'b1, 4'd6, 32'h66, 1'b0);
            chk1("fixed_a_ready", a_rdy[1], 1'b1);
            chk1("fixed_b_ready", b_rdy[1], 1'b0);
        end
        drive(1'b0, 4'd4, 32'h44, 1'b1, 4'd6, 32'h66, 1'b0);
        chk1("fixed_b_late", b_rdy[1], 1'b1);
        idle();
        chk("fixed_b_data", wres[1], 32'h66);

        // hold: no grants, count still advances, arbitration state untouched
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2, 1'b1);
            chk1("hold_a_ready", a_rdy[0], 1'b0);
            chk1("hold_b_ready", b_rdy[0], 1'b0);
        end
        drive(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2, 1'b0);
        chk1("hold_wr_en", we[0], 1'b0);
        chk("hold_count", {16'd0, cnt[0]}, 32'd3);
        chk1("hold_then_a", a_rdy[0], 1'b1);
        idle();

        // saturation: preload the counter and push three more conflicts
        #1;
        force dut0.conflict_count_r = 16'hFFFD;
        #1;
        release dut0.conflict_count_r;
        preload_val = 16'hFFFD;
        preload_seq = preload_seq + 1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd1, 32'hC1, 1'b1, 4'd2, 32'hC2, 1'b0);
        end
        chk("sat_count_ffff_a", {16'd0, cnt[0]}, 32'h0000FFFF);
        idle();
        chk("sat_count_ffff_b", {16'd0, cnt[0]}, 32'h0000FFFF);

        // asynchronous reset mid-stream; A wins first conflict afterwards
        drive(1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88, 1'b0);
        drive(1'b1, 4'd7, 32'h78, 1'b1, 4'd8, 32'h88, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_wr_en", we[0], 1'b0);
        chk("arst_wr_idx", {28'd0, widx[0]}, 32'd0);
        chk("arst_wr_data", wres[0], 32'h0);
        chk("arst_count", {16'd0, cnt[0]}, 32'd0);
        chk1("arst_a_ready", a_rdy[0], 1'b0);
        chk1("arst_b_ready", b_rdy[0], 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_a_wins", a_rdy[0], 1'b1);
        chk1("post_rst_wr_en", we[0], 1'b0);
        idle();
        chk1("post_rst_wr", we[0], 1'b1);
        chk("post_rst_data", wres[0], 32'h78);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
